// File: rtl/btb_update_ctrl.sv
// BTB/global-counter write sequencer between branch resolve and the predictor tables.
// Latency: counter pulse 1 cycle after accept; BTB write earliest the cycle after enqueue.
// Backpressure: res_ready low while sweeping or FIFO full; btb_stall holds FIFO and sweep.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   res_valid/res_ready           resolved-branch handshake (res_pc, res_target,
//                                 res_taken, res_mispredict qualify it)
//   btb_stall                     BTB port busy; suppresses btb_we this cycle
//   sweep_req                     pulse to re-clear the whole BTB
//   btb_we/btb_index/btb_wdata    BTB write port, wdata = {tag, target}
//   ctr_upd_valid/ctr_taken       registered global 2-bit counter update
//   init_busy                     clear sweep in progress
//   stat_updates/stat_coalesced   saturating statistics, only with BTB_UPD_STATS_EN
//
// Optional build macro: BTB_UPD_STATS_EN adds the two statistics outputs.

module btb_update_ctrl #(
  parameter int IDX_W      = 8,
  parameter int TAG_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [15:0]            res_pc,
  input  logic [15:0]            res_target,
  input  logic                   res_taken,
  input  logic                   res_mispredict,
  input  logic                   btb_stall,
  input  logic                   sweep_req,
  output logic                   btb_we,
  output logic [IDX_W-1:0]       btb_index,
  output logic [TAG_W+15:0]      btb_wdata,
  output logic                   ctr_upd_valid,
  output logic                   ctr_taken,
  output logic                   init_busy
`ifdef BTB_UPD_STATS_EN
  ,
  output logic [15:0]            stat_updates,
  output logic [15:0]            stat_coalesced
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;
  localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [15:0]      tgt;
  } entry_t;

  // State
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  // Low for the first cycle out of reset so no write strobe is seen while reset is applied.
  logic             arm_q, arm_d;
  entry_t           mem_q [FIFO_DEPTH];
  entry_t           mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             ctr_vld_q, ctr_vld_d;
  logic             ctr_tkn_q, ctr_tkn_d;

  // Per-cycle decode
  logic             in_init;
  logic             fifo_empty;
  logic             fifo_full;
  logic             accept;
  logic             sweep_go;
  logic             enq_req;
  logic             sweep_wr;
  logic             pop;
  logic             newest_hit;
  logic             coalesce;
  logic             alloc;
  logic [PTR_W-1:0] newest_ptr;
  entry_t           head;
  entry_t           new_ent;

  always_comb begin
    in_init    = (state_q == S_INIT);
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CNT_FULL);

    res_ready  = !in_init && !fifo_full;
    accept     = res_valid && res_ready;
    sweep_go   = sweep_req && !in_init;
    // A resolution accepted together with a sweep request still updates the
    // counter, but its BTB entry would be wiped by the sweep anyway.
    enq_req    = accept && res_taken && res_mispredict && !sweep_go;

    sweep_wr   = in_init && arm_q && !btb_stall;
    pop        = (state_q == S_DRAIN) && !fifo_empty && !btb_stall;

    head       = mem_q[rd_ptr_q];
    newest_ptr = wr_ptr_q - PTR_W'(1);

    new_ent.idx = res_pc[IDX_W-1:0];
    new_ent.tag = res_pc[15:16-TAG_W];
    new_ent.tgt = res_target;

    newest_hit = !fifo_empty && (mem_q[newest_ptr].idx == new_ent.idx);
    // When the newest entry is also the head leaving this cycle, overwriting it
    // would lose the update, so a fresh slot is taken instead.
    coalesce   = enq_req && newest_hit && !(pop && (cnt_q == CNT_ONE));
    alloc      = enq_req && !coalesce;
  end

  // BTB write port
  always_comb begin
    btb_we    = sweep_wr || pop;
    btb_index = '0;
    btb_wdata = '0;
    if (sweep_wr) begin
      btb_index = ptr_q;
      btb_wdata = {{TAG_W{1'b0}}, 16'hFFFF};
    end else if (pop) begin
      btb_index = head.idx;
      btb_wdata = {head.tag, head.tgt};
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    arm_d    = 1'b1;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    ctr_vld_d = accept;
    ctr_tkn_d = accept && res_taken;

    if (in_init) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      if (sweep_wr) begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == SWEEP_LAST) begin
          state_d = S_IDLE;
        end
      end
    end else if (sweep_go) begin
      state_d  = S_INIT;
      ptr_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (coalesce) begin
        mem_d[newest_ptr] = new_ent;
      end
      if (alloc) begin
        mem_d[wr_ptr_q] = new_ent;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      cnt_d   = cnt_q + {{PTR_W{1'b0}}, alloc} - {{PTR_W{1'b0}}, pop};
      state_d = (cnt_d != '0) ? S_DRAIN : S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_INIT;
      ptr_q     <= '0;
      arm_q     <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ctr_vld_q <= 1'b0;
      ctr_tkn_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      arm_q     <= arm_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      ctr_vld_q <= ctr_vld_d;
      ctr_tkn_q <= ctr_tkn_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ctr_upd_valid = ctr_vld_q;
  assign ctr_taken     = ctr_tkn_q;
  assign init_busy     = in_init;

`ifdef BTB_UPD_STATS_EN
  // Saturating statistics; survive sweeps, cleared only by reset.
  logic [15:0] stat_upd_q, stat_upd_d;
  logic [15:0] stat_coal_q, stat_coal_d;

  always_comb begin
    stat_upd_d  = stat_upd_q;
    stat_coal_d = stat_coal_q;
    if (pop && (stat_upd_q != 16'hFFFF)) begin
      stat_upd_d = stat_upd_q + 16'd1;
    end
    if (coalesce && (stat_coal_q != 16'hFFFF)) begin
      stat_coal_d = stat_coal_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_upd_q  <= '0;
      stat_coal_q <= '0;
    end else begin
      stat_upd_q  <= stat_upd_d;
      stat_coal_q <= stat_coal_d;
    end
  end

  assign stat_updates   = stat_upd_q;
  assign stat_coalesced = stat_coal_q;
`endif

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Self-checking bench for btb_update_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against a queue-based reference model.
module tb_btb_update_ctrl;

  logic        clk;
  logic        reset_n;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_pc;
  logic [15:0] res_target;
  logic        res_taken;
  logic        res_mispredict;
  logic        btb_stall;
  logic        sweep_req;
  logic        btb_we;
  logic [7:0]  btb_index;
  logic [23:0] btb_wdata;
  logic        ctr_upd_valid;
  logic        ctr_taken;
  logic        init_busy;

  btb_update_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_pc         (res_pc),
    .res_target     (res_target),
    .res_taken      (res_taken),
    .res_mispredict (res_mispredict),
    .btb_stall      (btb_stall),
    .sweep_req      (sweep_req),
    .btb_we         (btb_we),
    .btb_index      (btb_index),
    .btb_wdata      (btb_wdata),
    .ctr_upd_valid  (ctr_upd_valid),
    .ctr_taken      (ctr_taken),
    .init_busy      (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: pending updates as a queue of {index, tag, target}.
  typedef struct {
    logic [7:0]  idx;
    logic [7:0]  tag;
    logic [15:0] tgt;
  } ent_t;

  ent_t q[$];
  bit   m_sweeping;
  int   m_sidx;
  bit   m_armed;
  bit   m_cv;
  bit   m_ct;

  // Values observed at the last step's sampling point.
  logic        o_we;
  logic [7:0]  o_idx;
  logic [23:0] o_wd;
  logic        o_cv;
  logic        o_ct;
  logic        o_busy;
  int          we_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_sweeping = 1'b1;
    m_sidx     = 0;
    m_armed    = 1'b0;
    m_cv       = 1'b0;
    m_ct       = 1'b0;
  endtask

  task automatic drive(input bit v, input logic [15:0] pc, input logic [15:0] tgt,
                       input bit tk, input bit mp);
    res_valid      = v;
    res_pc         = pc;
    res_target     = tgt;
    res_taken      = tk;
    res_mispredict = mp;
  endtask

  // One clock: compare at negedge, advance model at posedge, return at posedge+1.
  task automatic step();
    bit          e_we;
    bit          e_rdy;
    logic [7:0]  e_idx;
    logic [23:0] e_wd;
    bit          acc;
    int          n0;
    ent_t        e;
    @(negedge clk);
    e_rdy = !m_sweeping && (q.size() < 4);
    e_idx = 8'h00;
    e_wd  = 24'h0;
    if (m_sweeping) begin
      e_we = m_armed && !btb_stall;
      if (e_we) begin
        e_idx = m_sidx[7:0];
        e_wd  = 24'h00FFFF;
      end
    end else begin
      e_we = (q.size() > 0) && !btb_stall;
      if (e_we) begin
        e_idx = q[0].idx;
        e_wd  = {q[0].tag, q[0].tgt};
      end
    end
    o_we = btb_we; o_idx = btb_index; o_wd = btb_wdata;
    o_cv = ctr_upd_valid; o_ct = ctr_taken; o_busy = init_busy;
    if (btb_we) we_count++;
    chk("btb_we",        32'(btb_we),        32'(e_we));
    chk("btb_index",     32'(btb_index),     32'(e_idx));
    chk("btb_wdata",     32'(btb_wdata),     32'(e_wd));
    chk("res_ready",     32'(res_ready),     32'(e_rdy));
    chk("init_busy",     32'(init_busy),     32'(m_sweeping));
    chk("ctr_upd_valid", 32'(ctr_upd_valid), 32'(m_cv));
    chk("ctr_taken",     32'(ctr_taken),     32'(m_ct));
    @(posedge clk);
    if (reset_n) begin
      acc = res_valid && e_rdy;
      if (m_sweeping) begin
        if (e_we) begin
          if (m_sidx == 255) m_sweeping = 1'b0;
          m_sidx++;
        end
      end else if (sweep_req) begin
        q.delete();
        m_sweeping = 1'b1;
        m_sidx     = 0;
      end else begin
        n0 = q.size();
        if (e_we) void'(q.pop_front());
        if (acc && res_taken && res_mispredict) begin
          e.idx = res_pc[7:0];
          e.tag = res_pc[15:8];
          e.tgt = res_target;
          if (n0 > 0 && !(n0 == 1 && e_we) && q[$].idx == e.idx) begin
            q[$].tag = e.tag;
            q[$].tgt = e.tgt;
          end else begin
            q.push_back(e);
          end
        end
      end
      m_armed = 1'b1;
      m_cv    = acc;
      m_ct    = acc && res_taken;
    end
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    btb_stall = 1'b0;
    sweep_req = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    model_reset();
    we_count = 0;

    // Reset state
    #2;
    step();
    chk("rst_busy", 32'(o_busy), 32'd1);
    chk("rst_we",   32'(o_we),   32'd0);
    chk("rst_cv",   32'(o_cv),   32'd0);

    // 1: full sweep after reset release
    reset_n  = 1'b1;
    we_count = 0;
    repeat (257) step();
    chk("sweep_count", 32'(we_count), 32'd256);
    chk("sweep_last_idx", 32'(o_idx), 32'hFF);
    chk("ready_after_sweep", 32'(res_ready), 32'd1);
    chk("busy_after_sweep", 32'(init_busy), 32'd0);

    // 2: single taken mispredict
    drive(1'b1, 16'h1234, 16'h1250, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("t2_cv", 32'(o_cv), 32'd1);
    chk("t2_ct", 32'(o_ct), 32'd1);
    chk("t2_we", 32'(o_we), 32'd1);
    chk("t2_idx", 32'(o_idx), 32'h34);
    chk("t2_wd", 32'(o_wd), 32'h121250);

    // 3: fill FIFO under stall, then drain in order
    btb_stall = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h5500 + 16'(i), 16'h7000 + 16'(i), 1'b1, 1'b1);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("t3_full_ready", 32'(res_ready), 32'd0);
    btb_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("t3_we", 32'(o_we), 32'd1);
      chk("t3_idx", 32'(o_idx), 32'(i));
    end

    // 4: coalesce into newest entry
    btb_stall = 1'b1;
    drive(1'b1, 16'h0110, 16'h0200, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h0210, 16'h0300, 1'b1, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    btb_stall = 1'b0;
    step();
    chk("t4_we", 32'(o_we), 32'd1);
    chk("t4_idx", 32'(o_idx), 32'h10);
    chk("t4_wd", 32'(o_wd), 32'h020300);
    step();
    chk("t4_single", 32'(o_we), 32'd0);

    // 5: not-taken resolution
    drive(1'b1, 16'(($urandom)), 16'(($urandom)), 1'b0, 1'b1);
    step();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("t5_cv", 32'(o_cv), 32'd1);
    chk("t5_ct", 32'(o_ct), 32'd0);
    chk("t5_we", 32'(o_we), 32'd0);
    step();
    chk("t5_we_later", 32'(o_we), 32'd0);

    // 7: same index as head being written must allocate a new slot
    drive(1'b1, 16'hAA20, 16'h1111, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'hBB20, 16'h2222, 1'b1, 1'b1);
    step();
    chk("t7_first_wd", 32'(o_wd), 32'hAA1111);
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    chk("t7_second_wd", 32'(o_wd), 32'hBB2222);

    // 6: sweep_req with pending entries and a same-cycle accept
    btb_stall = 1'b1;
    drive(1'b1, 16'h0141, 16'h4000, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h0142, 16'h4100, 1'b1, 1'b1);
    step();
    drive(1'b1, 16'h0143, 16'h4200, 1'b1, 1'b1);
    sweep_req = 1'b1;
    step();
    sweep_req = 1'b0;
    btb_stall = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    we_count = 0;
    step();
    chk("t6_cv", 32'(o_cv), 32'd1);
    chk("t6_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 300 && !(m_sweeping && m_sidx == 100); i++) step();
    chk("t6_reached_100", 32'(o_idx), 32'd99);
    reset_n = 1'b0;
    model_reset();
    step();
    reset_n  = 1'b1;
    we_count = 0;
    step();
    step();
    chk("t6_restart_we", 32'(o_we), 32'd1);
    chk("t6_restart_idx", 32'(o_idx), 32'd0);
    repeat (255) step();
    chk("t6_sweep_count", 32'(we_count), 32'd256);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] ix;
      case ($urandom_range(0, 3))
        0: ix = 8'h10;
        1: ix = 8'h11;
        2: ix = 8'h12;
        default: ix = 8'($urandom);
      endcase
      drive($urandom_range(0, 9) < 6, {8'($urandom), ix}, 16'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6);
      btb_stall = $urandom_range(0, 9) < 3;
      sweep_req = $urandom_range(0, 499) == 0;
      step();
    end
    sweep_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
